booth_mul_seq: RTL and testbench

Iterative radix-4 Booth multiplier with valid/ready handshakes on both sides. It processes a configurable number of Booth digits per cycle and selects signed or unsigned operation per transaction. Optional low-order truncation provides an approximate product. It is the next-generation processing-element multiplier for the systolic array, sitting between operand skew registers and the accumulator.

---
 rtl/booth_mul_seq_if.sv | 26 ++
 rtl/booth_mul_seq.sv | 113 +++++++++++
 tb/tb_booth_mul_seq.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/booth_mul_seq_if.sv
// Operand/product handshake bundle for the radix-4 Booth multiplier.
// The master side supplies operands and consumes products; the slave side is the multiplier.
interface booth_mul_seq_if #(
  parameter int WIDTH_A = 16,
  parameter int WIDTH_B = 16
) ();
  logic                       in_valid;
  logic                       in_ready;
  logic [WIDTH_A-1:0]         a;
  logic [WIDTH_B-1:0]         b;
  logic                       signed_mode;
  logic                       out_valid;
  logic                       out_ready;
  logic [WIDTH_A+WIDTH_B-1:0] out_p;
  logic                       busy;

  modport master (
    output in_valid, a, b, signed_mode, out_ready,
    input  in_ready, out_valid, out_p, busy
  );

  modport slave (
    input  in_valid, a, b, signed_mode, out_ready,
    output in_ready, out_valid, out_p, busy
  );
endinterface

// File: rtl/booth_mul_seq.sv
// Iterative radix-4 Booth multiplier retiring DIGITS_PER_CYC digits per cycle,
// signed/unsigned per transaction, with optional zeroing of low product bits.
module booth_mul_seq #(
  parameter int WIDTH_A        = 16,
  parameter int WIDTH_B        = 16,
  parameter int DIGITS_PER_CYC = 1,
  parameter int APPROX_W       = 0
) (
  input logic            clk,
  input logic            rst_n,
  booth_mul_seq_if.slave bus
);
  localparam int unsigned NDIG = WIDTH_B / 2 + 1;
  localparam int unsigned PW   = WIDTH_A + WIDTH_B;
  localparam int unsigned AW   = PW + 2;
  localparam int unsigned BW   = 2 * NDIG + 1;   // includes the implicit b[-1] at bit 0
  localparam int unsigned DPC  = DIGITS_PER_CYC;
  localparam int unsigned IW   = $clog2(NDIG + DPC + 1);
  localparam logic [PW-1:0] OUT_MASK = {PW{1'b1}} << APPROX_W;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [WIDTH_A-1:0] a_q;
  logic [WIDTH_B-1:0] b_q;
  logic               signed_q;
  logic [AW-1:0]      acc_q, acc_d;
  logic [IW-1:0]      idx_q;
  logic [PW-1:0]      p_q;

  logic               accept;
  logic               last_cyc;
  logic [AW-1:0]      a_ext;
  logic [BW-1:0]      b_ext;
  logic [31:0]        dig;
  logic [2:0]         trip;
  logic [AW-1:0]      a_sh;

  assign accept   = bus.in_valid && (state_q == S_IDLE);
  assign last_cyc = (32'(idx_q) + DPC) >= NDIG;

  // Operands are stored raw; the registered mode decides how they extend.
  assign a_ext = {{(AW - WIDTH_A){signed_q & a_q[WIDTH_A-1]}}, a_q};
  assign b_ext = {{(BW - 1 - WIDTH_B){signed_q & b_q[WIDTH_B-1]}}, b_q, 1'b0};

  // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    acc_d = acc_q;
    dig   = '0;
    trip  = '0;
    a_sh  = '0;
    for (int j = 0; j < DIGITS_PER_CYC; j++) begin
      dig  = 32'(idx_q) + 32'(j);
      trip = 3'(b_ext >> (2 * dig));
      a_sh = a_ext << (2 * dig);
      // Digits past the top one are out of range and contribute nothing.
      if (dig < NDIG) begin
        case (trip)
          3'b001, 3'b010: acc_d = acc_d + a_sh;
          3'b011:         acc_d = acc_d + (a_sh << 1);
          3'b100:         acc_d = acc_d - (a_sh << 1);
          3'b101, 3'b110: acc_d = acc_d - a_sh;
          default:        ;
        endcase
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.in_valid) state_d = S_CALC;
      S_CALC:  if (last_cyc)     state_d = S_DONE;
      S_DONE:  if (bus.out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      signed_q <= 1'b0;
      acc_q    <= '0;
      idx_q    <= '0;
      p_q      <= '0;
    end else if (accept) begin
      a_q      <= bus.a;
      b_q      <= bus.b;
      signed_q <= bus.signed_mode;
      acc_q    <= '0;
      idx_q    <= '0;
    end else if (state_q == S_CALC) begin
      acc_q <= acc_d;
      idx_q <= idx_q + IW'(DPC);
      if (last_cyc) p_q <= acc_d[PW-1:0] & OUT_MASK;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.out_p     = p_q;
endmodule

// File: tb/tb_booth_mul_seq.sv
// Self-checking bench: three 16x16 multiplier instances (different digits/cycle and truncation)
// driven with directed corners and random traffic against an arithmetic reference model.
module tb_booth_mul_seq;
  localparam int NDIG = 16 / 2 + 1;

  function automatic int dpc_of(input int sel);
    return (sel == 0) ? 1 : ((sel == 1) ? 3 : 2);
  endfunction

  function automatic int approx_of(input int sel);
    return (sel == 1) ? 8 : 0;
  endfunction

  function automatic int ncyc_of(input int sel);
    return (NDIG + dpc_of(sel) - 1) / dpc_of(sel);
  endfunction

  logic clk;
  logic rst_n;

  logic        in_valid    [3];
  logic        out_ready   [3];
  logic        signed_mode [3];
  logic [15:0] a           [3];
  logic [15:0] b           [3];
  logic        in_ready    [3];
  logic        out_valid   [3];
  logic        busy        [3];
  logic [31:0] out_p       [3];

  int n_checks = 0;
  int n_pass   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    booth_mul_seq_if #(.WIDTH_A(16), .WIDTH_B(16)) bus_if ();

    booth_mul_seq #(
      .WIDTH_A       (16),
      .WIDTH_B       (16),
      .DIGITS_PER_CYC(dpc_of(g)),
      .APPROX_W      (approx_of(g))
    ) u_dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus_if)
    );

    assign bus_if.in_valid    = in_valid[g];
    assign bus_if.a           = a[g];
    assign bus_if.b           = b[g];
    assign bus_if.signed_mode = signed_mode[g];
    assign bus_if.out_ready   = out_ready[g];
    assign in_ready[g]        = bus_if.in_ready;
    assign out_valid[g]       = bus_if.out_valid;
    assign busy[g]            = bus_if.busy;
    assign out_p[g]           = bus_if.out_p;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // Reference: extend both operands as plain integers, multiply, keep PW bits, zero the low ones.
  function automatic logic [31:0] model(input logic [15:0] av, input logic [15:0] bv,
                                        input logic sm, input int aw);
    longint x, y;
    logic [63:0] p;
    x = sm ? longint'($signed(av)) : longint'(av);
    y = sm ? longint'($signed(bv)) : longint'(bv);
    p = 64'(x * y);
    return p[31:0] & (32'hFFFF_FFFF << aw);
  endfunction

  task automatic run_txn(input int sel, input logic [15:0] av, input logic [15:0] bv,
                         input logic sm, input int stall);
    logic [31:0] exp_p;
    int guard;
    int lat;
    exp_p = model(av, bv, sm, approx_of(sel));
    out_ready[sel] = (stall == 0);
    guard = 0;
    while (!in_ready[sel] && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    check("in_ready_before_accept", 64'(in_ready[sel]), 64'd1);
    a[sel] = av;
    b[sel] = bv;
    signed_mode[sel] = sm;
    in_valid[sel] = 1'b1;
    @(posedge clk); #1;
    in_valid[sel] = 1'b0;
    a[sel] = 16'($urandom);
    b[sel] = 16'($urandom);
    signed_mode[sel] = 1'($urandom);
    lat = 0;
    while (!out_valid[sel] && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", 64'(lat), 64'(ncyc_of(sel)));
    check("product", 64'(out_p[sel]), 64'(exp_p));
    for (int k = 0; k < stall; k++) begin
      in_valid[sel] = 1'b1;
      a[sel] = 16'($urandom);
      b[sel] = 16'($urandom);
      @(posedge clk); #1;
      check("hold_out_p", 64'(out_p[sel]), 64'(exp_p));
      check("hold_out_valid", 64'(out_valid[sel]), 64'd1);
      check("hold_in_ready", 64'(in_ready[sel]), 64'd0);
    end
    in_valid[sel] = 1'b0;
    out_ready[sel] = 1'b1;
    @(posedge clk); #1;
    check("post_hs_out_valid", 64'(out_valid[sel]), 64'd0);
    check("post_hs_in_ready", 64'(in_ready[sel]), 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic stray;
    for (int s = 0; s < 3; s++) begin
      in_valid[s] = 1'b0;
      out_ready[s] = 1'b0;
      signed_mode[s] = 1'b0;
      a[s] = '0;
      b[s] = '0;
    end
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    for (int s = 0; s < 3; s++) begin
      check("reset_in_ready", 64'(in_ready[s]), 64'd1);
      check("reset_out_valid", 64'(out_valid[s]), 64'd0);
      check("reset_busy", 64'(busy[s]), 64'd0);
      check("reset_out_p", 64'(out_p[s]), 64'd0);
    end

    // Directed corners on the one-digit-per-cycle instance.
    run_txn(0, 16'hFFFF, 16'hFFFF, 1'b0, 0);
    check("unsigned_max", 64'(out_p[0]), 64'h0000_0000_FFFE_0001);
    run_txn(0, 16'h8000, 16'h8000, 1'b1, 0);
    check("signed_min_sq", 64'(out_p[0]), 64'h0000_0000_4000_0000);
    run_txn(0, 16'hFFFD, 16'h0005, 1'b1, 0);
    check("signed_neg3x5", 64'(out_p[0]), 64'h0000_0000_FFFF_FFF1);
    run_txn(0, 16'h7FFF, 16'h8000, 1'b1, 0);
    check("signed_max_min", 64'(out_p[0]), 64'h0000_0000_C000_8000);
    run_txn(0, 16'hFFFD, 16'h0005, 1'b0, 0);
    check("unsigned_fffd_x5", 64'(out_p[0]), 64'h0000_0000_0004_FFF1);

    // Backpressure for 5 cycles with operand pulses that must be ignored.
    run_txn(0, 16'h1357, 16'h2468, 1'b0, 5);
    @(posedge clk); #1;
    check("no_queued_beat_busy", 64'(busy[0]), 64'd0);
    check("bp_out_p_kept", 64'(out_p[0]), 64'(model(16'h1357, 16'h2468, 1'b0, 0)));

    // Reset during the 4th CALC cycle.
    a[0] = 16'h4321;
    b[0] = 16'h1234;
    signed_mode[0] = 1'b0;
    out_ready[0] = 1'b1;
    in_valid[0] = 1'b1;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_in_ready", 64'(in_ready[0]), 64'd1);
    check("midrst_out_valid", 64'(out_valid[0]), 64'd0);
    check("midrst_busy", 64'(busy[0]), 64'd0);
    check("midrst_out_p", 64'(out_p[0]), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    stray = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (out_valid[0] || busy[0]) stray = 1'b1;
    end
    check("midrst_no_stray", 64'(stray), 64'd0);
    run_txn(0, 16'h0003, 16'h0007, 1'b0, 0);
    check("after_reset_3x7", 64'(out_p[0]), 64'h0000_0000_0000_0015);

    // Truncated product with three digits per cycle.
    run_txn(1, 16'h1234, 16'h5678, 1'b0, 0);
    check("approx_1234x5678", 64'(out_p[1]), 64'h0000_0000_0626_0000);

    // Random back-to-back traffic with random stalls on every instance.
    for (int s = 0; s < 3; s++) begin
      for (int n = 0; n < 800; n++) begin
        run_txn(s, 16'($urandom), 16'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
